// File: rtl/signed_min_max_reducer.sv
// signed_min_max_reducer: streaming signed min/max reduction with first-occurrence positions
//
// Ports:
//    clk, rst_n                  rising-edge clock, synchronous active-low reset
//    in_valid/in_ready           input beat handshake (in_ready high while accumulating)
//    in_value, in_active         signed beat value; inactive beats only advance the index
//    in_last                     final beat of the batch
//    out_valid/out_ready         result handshake (out_valid high while holding a result)
//    out_min, out_max            signed extrema over active beats (0 when none)
//    out_min_idx, out_max_idx    0-based beat index of the first occurrence, saturating
//    out_count, out_any          active-beat count (saturating) and non-empty flag
module signed_min_max_reducer #(
   parameter int WIDTH = 8,
   parameter int IDX_W = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] in_value,
   input  logic                    in_active,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] out_min,
   output logic signed [WIDTH-1:0] out_max,
   output logic [IDX_W-1:0]        out_min_idx,
   output logic [IDX_W-1:0]        out_max_idx,
   output logic [IDX_W-1:0]        out_count,
   output logic                    out_any
);
   localparam logic [0:0] ACCUM = 1'b0;
   localparam logic [0:0] HOLD  = 1'b1;
   localparam logic signed [WIDTH-1:0] VAL_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] VAL_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [0:0]              state_q;
   logic signed [WIDTH-1:0] min_q, max_q;
   logic [IDX_W-1:0]        min_idx_q, max_idx_q, beat_idx_q, count_q;
   logic                    any_q;
   logic                    accept;

   assign in_ready  = state_q == ACCUM;
   assign out_valid = state_q == HOLD;
   assign accept    = in_valid & in_ready;

   // A released result clears the accumulators exactly like reset does.
   always_ff @(posedge clk) begin
      if (!rst_n || (state_q == HOLD && out_ready)) begin
         state_q    <= ACCUM;
         min_q      <= VAL_MAX;
         max_q      <= VAL_MIN;
         min_idx_q  <= '0;
         max_idx_q  <= '0;
         beat_idx_q <= '0;
         count_q    <= '0;
         any_q      <= 1'b0;
      end else if (accept) begin
         if (in_active) begin
            // Strict compares keep the earliest beat on ties.
            if (!any_q || in_value < min_q) begin
               min_q     <= in_value;
               min_idx_q <= beat_idx_q;
            end
            if (!any_q || in_value > max_q) begin
               max_q     <= in_value;
               max_idx_q <= beat_idx_q;
            end
            count_q <= &count_q ? count_q : count_q + 1'b1;
            any_q   <= 1'b1;
         end
         beat_idx_q <= &beat_idx_q ? beat_idx_q : beat_idx_q + 1'b1;
         if (in_last) state_q <= HOLD;
      end
   end

   // Empty batches report all zeros rather than the accumulator sentinels.
   assign out_min     = any_q ? min_q : '0;
   assign out_max     = any_q ? max_q : '0;
   assign out_min_idx = any_q ? min_idx_q : '0;
   assign out_max_idx = any_q ? max_idx_q : '0;
   assign out_count   = count_q;
   assign out_any     = any_q;
endmodule

// File: tb/tb_signed_min_max_reducer.sv
// tb_signed_min_max_reducer: randomized and directed checks against a batch-level model
module tb_signed_min_max_reducer;
   localparam int W    = 8;
   localparam int IW   = 3;
   localparam int MAXI = (1 << IW) - 1;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                in_valid = 1'b0, in_active = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic signed [W-1:0] in_value = '0;
   logic                in_ready, out_valid, out_any;
   logic signed [W-1:0] out_min, out_max;
   logic [IW-1:0]       out_min_idx, out_max_idx, out_count;

   int n_tests = 0, n_fail = 0;
   logic signed [W-1:0] bv[$];
   bit                  ba[$];

   always #5 clk = ~clk;

   signed_min_max_reducer #(.WIDTH(W), .IDX_W(IW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
      .in_active(in_active), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_min(out_min), .out_max(out_max),
      .out_min_idx(out_min_idx), .out_max_idx(out_max_idx),
      .out_count(out_count), .out_any(out_any)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input int v, input bit a);
      bv.push_back(W'(v));
      ba.push_back(a);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 1);
      check({tag, "_out_valid"}, 32'(out_valid), 0);
      check({tag, "_any"}, 32'(out_any), 0);
      check({tag, "_count"}, 32'(out_count), 0);
      check({tag, "_min"}, 32'(out_min), 0);
      check({tag, "_max"}, 32'(out_max), 0);
      check({tag, "_min_idx"}, 32'(out_min_idx), 0);
      check({tag, "_max_idx"}, 32'(out_max_idx), 0);
   endtask

   // Sends the queued batch, checks the result against the model, holds it for
   // hold_n cycles, then releases it (or resets it away when rst_hold is set).
   task automatic run_batch(input string tag, input int hold_n, input bit gaps, input bit rst_hold);
      int                  cnt = 0, mni = 0, mxi = 0, idx;
      logic signed [W-1:0] mn = '0, mx = '0;
      logic [IW-1:0]       e_cnt;
      for (int i = 0; i < bv.size(); i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            @(negedge clk);
            in_valid = 1'b0; in_value = W'($urandom); in_active = 1'b1; in_last = 1'b1;
            @(posedge clk);
         end
         @(negedge clk);
         check({tag, "_beat_ready"}, 32'(in_ready), 1);
         check({tag, "_beat_valid"}, 32'(out_valid), 0);
         in_valid = 1'b1; in_value = bv[i]; in_active = ba[i]; in_last = (i == bv.size() - 1);
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      for (int i = 0; i < bv.size(); i++) begin
         if (ba[i]) begin
            idx = i > MAXI ? MAXI : i;
            if (cnt == 0 || bv[i] < mn) begin mn = bv[i]; mni = idx; end
            if (cnt == 0 || bv[i] > mx) begin mx = bv[i]; mxi = idx; end
            cnt++;
         end
      end
      e_cnt = IW'(cnt > MAXI ? MAXI : cnt);
      for (int c = 0; c <= hold_n; c++) begin
         check({tag, "_out_valid"}, 32'(out_valid), 1);
         check({tag, "_hold_ready"}, 32'(in_ready), 0);
         check({tag, "_min"}, 32'(out_min), 32'(mn));
         check({tag, "_max"}, 32'(out_max), 32'(mx));
         check({tag, "_min_idx"}, 32'(out_min_idx), 32'(mni));
         check({tag, "_max_idx"}, 32'(out_max_idx), 32'(mxi));
         check({tag, "_count"}, 32'(out_count), 32'(e_cnt));
         check({tag, "_any"}, 32'(out_any), 32'(cnt > 0));
         if (c < hold_n) begin
            in_valid = 1'b1; in_value = W'($urandom); in_active = 1'b1; in_last = 1'b1;
            @(posedge clk);
            @(negedge clk);
         end
      end
      if (rst_hold) rst_n = 1'b0; else out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      check_idle({tag, "_released"});
      bv.delete();
      ba.delete();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_idle("reset");

      push(5, 1); push(-3, 1); push(7, 0); push(-3, 1); push(12, 1);
      run_batch("basic", 0, 0, 0);
      push(-128, 0); push(127, 0); push(0, 0);
      run_batch("inactive", 0, 0, 0);
      push(-128, 1); push(127, 1);
      run_batch("extremes", 0, 0, 0);
      push(42, 1);
      run_batch("single", 0, 0, 0);
      push(9, 1); push(-9, 1);
      run_batch("backpressure", 5, 0, 0);
      push(3, 1); push(3, 1); push(-1, 0);
      run_batch("after_bp", 0, 0, 0);
      for (int i = 0; i < 10; i++) push(20 - i, 1);
      run_batch("saturate", 0, 0, 0);

      @(negedge clk);
      in_valid = 1'b1; in_value = 50; in_active = 1'b1; in_last = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_value = -50;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_idle("mid_reset");
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         check("mid_reset_no_valid", 32'(out_valid), 0);
      end
      push(1, 1);
      run_batch("post_reset", 0, 0, 0);
      push(-7, 1); push(4, 1);
      run_batch("hold_reset", 2, 0, 1);
      push(6, 1);
      run_batch("post_hold_reset", 0, 0, 0);

      for (int b = 0; b < 40; b++) begin
         int n = $urandom_range(1, 12);
         for (int i = 0; i < n; i++)
            push($urandom_range(0, 1) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 4)) - 2,
                 $urandom_range(0, 9) < 7);
         run_batch("random", $urandom_range(0, 3), 1, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/signed_min_max_reducer.md
# signed_min_max_reducer

Streaming reduction block that takes a batch of signed, individually activated values one per cycle and reports the minimum, the maximum and their positions over the activated entries only. It generalises the two-input combinational minimum selector to N-entry batches, any data width, and both extrema at once. Typical placement is between a constraint-coefficient stream and the bound-update logic of the solver.

## Interface
- `WIDTH`, 8: data width, two's-complement signed.
- `IDX_W`, 6: width of beat index and active count; batches up to 2^IDX_W beats are fully indexed.
- `clk` input 1: single clock; all logic rising-edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_valid` input 1: input beat present.
- `in_ready` output 1: block accepts a beat this cycle.
- `in_value` input WIDTH: signed value.
- `in_active` input 1: beat takes part in the comparison; inactive beats are consumed but ignored.
- `in_last` input 1: final beat of the batch.
- `out_valid` output 1: result held.
- `out_ready` input 1: consumer takes result.
- `out_min`, `out_max` output WIDTH: signed extrema of active beats.
- `out_min_idx`, `out_max_idx` output IDX_W: beat index (0-based within the batch) of the extrema.
- `out_count` output IDX_W: number of active beats, saturating.
- `out_any` output 1: at least one active beat in the batch.

## Operation
- FSM with two states: ACCUM (`in_ready`=1, `out_valid`=0) and HOLD (`in_ready`=0, `out_valid`=1).
- Reset state is ACCUM. Accumulators are cleared on reset: min=2^(WIDTH-1)-1, max=-2^(WIDTH-1), beat index=0, count=0, any=0.
- Accepted beat means `in_valid & in_ready`. For an accepted beat with `in_active`=1:
  - Min is updated when the beat is strictly less than the current min, or when any=0.
  - Max is updated when the beat is strictly greater than the current max, or when any=0.
  - When an extremum is updated, its index is set to the current beat index.
  - count increments and saturates at 2^IDX_W-1; any is set to 1.
- On ties the earliest beat wins (strict compare), so `out_*_idx` is the first occurrence.
- Every accepted beat, active or not, increments the beat index. The index saturates at 2^IDX_W-1.
- An accepted beat with `in_last`=1 is folded into the result, then the FSM moves to HOLD. The outputs reflect the batch including that beat.
- In HOLD, `out_*` are stable until `out_ready`=1. On that edge the FSM returns to ACCUM and all accumulators are cleared to their reset values.
- Empty batch (no active beats, including a single inactive beat with `in_last`): `out_any`=0, `out_count`=0, and `out_min`, `out_max`, `out_min_idx`, `out_max_idx` are all 0. Outputs are forced to 0 whenever any=0.
- Comparisons are full signed WIDTH-bit. There is no arithmetic, so no overflow is possible.

## Timing
- Reset values of all outputs: `in_ready`=1, `out_valid`=0, and every other output 0.
- Throughput is one beat per cycle inside a batch.
- Latency: `out_valid` rises on the cycle after the `in_last` beat is accepted.
- There is a minimum one-cycle bubble between batches: HOLD lasts at least one cycle, and `in_ready`=0 while in HOLD.
- If `out_ready`=1 during the first HOLD cycle, `in_ready` is 1 again on the following cycle.
- `in_*` are ignored when `in_ready`=0, and `out_ready` is ignored when `out_valid`=0.
- If `rst_n` is low mid-batch or during HOLD, the next cycle is ACCUM with cleared accumulators. Partial results are discarded and no `out_valid` pulse is produced.
- `in_ready` and `out_valid` are pure functions of state, with no combinational path from inputs.

## Test plan
- Batch with `WIDTH`=8: (5,a), (-3,a), (7,inactive), (-3,a), (12,a,last) -> `out_min`=-3, `out_min_idx`=1, `out_max`=12, `out_max_idx`=4, `out_count`=4, `out_any`=1; `out_valid` rises one cycle after the last beat.
- All inactive, 3 beats: (-128), (127), (0,last) -> `out_any`=0, `out_count`=0, all value and index outputs 0.
- Extremes: (-128,a), (127,a,last) -> `out_min`=-128 idx 0, `out_max`=127 idx 1. Then a single-beat batch (42,a,last) -> min=max=42, both idx 0, confirming the accumulators cleared.
- Backpressure: hold `out_ready`=0 for 5 cycles with `in_valid`=1 -> `in_ready`=0 and outputs stable throughout. Drive `out_ready`=1 -> `in_ready`=1 on the next cycle, and the next batch is accepted correctly.
- With `IDX_W`=2: batch of 6 active beats, minimum at beat 5 -> `out_count`=3 (saturated) and `out_min_idx`=3 (saturated).
- Drive `rst_n`=0 for 1 cycle after 2 beats of a batch -> no `out_valid`. A following batch (1,a,last) reports min=max=1, count=1.
